// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency RAM port between the instruction
// fetch requester (read only) and the MEM-stage requester (read/write).
// At most one RAM access is outstanding. Completion of an access hands the
// port straight to the other requester when it is waiting.
// Optional build macro ARB_FAIR_EN: when both requesters contend at an
// arbitration point, grant the one not served last (lastGrant register).
// Without it, MEM always wins over IF.
module mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch-stage requester
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifDone,
    output logic [DATA_W-1:0] ifRdata,
    output logic              ifStall,
    // MEM-stage requester
    input  logic              memReq,
    input  logic              memWe,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memWdata,
    output logic              memDone,
    output logic [DATA_W-1:0] memRdata,
    output logic              memStall,
    // shared RAM port
    output logic              ramReq,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramWdata,
    input  logic              ramReady,
    input  logic [DATA_W-1:0] ramRdata,
    // contention statistics
    output logic [15:0]       conflictCnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic if_req_eff;
    logic mem_req_eff;
    logic grant_if;
    logic grant_mem;
    logic if_fin;
    logic mem_fin;
    logic acc_fin;

`ifdef ARB_FAIR_EN
    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t last_grant;
`endif

    // A requester whose done pulse is high this cycle is still holding req
    // for the access that just finished; it must not win a second grant.
    assign if_req_eff  = ifReq  & ~ifDone;
    assign mem_req_eff = memReq & ~memDone;

    // RAM completion only counts while an access is actually outstanding.
    assign if_fin  = (state == IF_ACC)  & ramReady;
    assign mem_fin = (state == MEM_ACC) & ramReady;
    assign acc_fin = if_fin | mem_fin;

    assign ifStall  = ifReq  & ~ifDone;
    assign memStall = memReq & ~memDone;

    // Next-state and grant decode; grants fire on the edge entering *_ACC.
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        unique case (state)
            IDLE: begin
`ifdef ARB_FAIR_EN
                if (if_req_eff && mem_req_eff) begin
                    if (last_grant == GRANT_IF) begin
                        grant_mem = 1'b1;
                    end else begin
                        grant_if = 1'b1;
                    end
                end else if (mem_req_eff) begin
                    grant_mem = 1'b1;
                end else if (if_req_eff) begin
                    grant_if = 1'b1;
                end
`else
                if (mem_req_eff) begin
                    grant_mem = 1'b1;
                end else if (if_req_eff) begin
                    grant_if = 1'b1;
                end
`endif
            end
            IF_ACC: begin
                if (ramReady && mem_req_eff) begin
                    grant_mem = 1'b1;
                end else if (ramReady) begin
                    state_nxt = IDLE;
                end
            end
            MEM_ACC: begin
                if (ramReady && if_req_eff) begin
                    grant_if = 1'b1;
                end else if (ramReady) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (grant_mem) begin
            state_nxt = MEM_ACC;
        end else if (grant_if) begin
            state_nxt = IF_ACC;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RAM command register: loaded from the granted requester, held until
    // ramReady, dropped when no further grant follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramReq   <= 1'b0;
            ramWe    <= 1'b0;
            ramAddr  <= '0;
            ramWdata <= '0;
        end else if (grant_mem) begin
            ramReq   <= 1'b1;
            ramWe    <= memWe;
            ramAddr  <= memAddr;
            ramWdata <= memWdata;
        end else if (grant_if) begin
            ramReq   <= 1'b1;
            ramWe    <= 1'b0;
            ramAddr  <= ifAddr;
            ramWdata <= '0;
        end else if (acc_fin) begin
            ramReq <= 1'b0;
            ramWe  <= 1'b0;
        end
    end

    // One-cycle completion pulses, one edge after ramReady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifDone  <= 1'b0;
            memDone <= 1'b0;
        end else begin
            ifDone  <= if_fin;
            memDone <= mem_fin;
        end
    end

    // Read data capture on the same edge as the done pulse; stores leave
    // memRdata untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifRdata  <= '0;
            memRdata <= '0;
        end else begin
            if (if_fin) begin
                ifRdata <= ramRdata;
            end
            if (mem_fin && !ramWe) begin
                memRdata <= ramRdata;
            end
        end
    end

    // Saturating count of cycles where both requesters are stalled, i.e.
    // one of them is being kept off the RAM port by the other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflictCnt <= '0;
        end else if (ifStall && memStall && (conflictCnt != 16'hFFFF)) begin
            conflictCnt <= conflictCnt + 16'd1;
        end
    end

`ifdef ARB_FAIR_EN
    // Remember who was granted last so a tie goes to the other requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_IF;
        end else if (grant_mem) begin
            last_grant <= GRANT_MEM;
        end else if (grant_if) begin
            last_grant <= GRANT_IF;
        end
    end
`endif

endmodule
